// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared state type, default parameters and helpers for run_ctrl
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } run_state_e;

  localparam int unsigned DEF_RST_CYCLES = 2;
  localparam int unsigned DEF_MAX_CYCLES = 35;
  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned DEF_HALT_W     = 1;
  localparam bit          DEF_HALT_ALL   = 1'b0;

  // A zero-length core reset would skip RESET entirely; hold it for at least one cycle.
  function automatic int unsigned rst_hold_len(input int unsigned rst_cycles);
    return (rst_cycles == 0) ? 1 : rst_cycles;
  endfunction

  function automatic int unsigned hold_cnt_width(input int unsigned hold_len);
    return (hold_len > 1) ? $clog2(hold_len) : 1;
  endfunction

endpackage

// File: rtl/run_ctrl_cnt.sv
// rtl/run_ctrl_cnt.sv - saturating, clearable RUN-cycle counter
module run_ctrl_cnt
  import run_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over increment; the count sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - core run controller FSM; RUN_CTRL_WDOG_EN compiles in the RUN watchdog
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
  parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned HALT_W     = DEF_HALT_W,
  parameter bit          HALT_ALL   = DEF_HALT_ALL
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [HALT_W-1:0] halt_i,
  output logic              core_rst_o,
  output logic              core_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  cycles_o
);

`ifdef RUN_CTRL_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  localparam int unsigned      RST_LEN   = rst_hold_len(RST_CYCLES);
  localparam int unsigned      RST_W     = hold_cnt_width(RST_LEN);
  localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_LEN - 1);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(MAX_CYCLES - 1);

  run_state_e       state_q;
  run_state_e       state_d;
  logic [RST_W-1:0] hold_q;
  logic [RST_W-1:0] hold_d;
  logic             halt_hit;
  logic             wdog_hit;
  logic             cnt_clr;
  logic             cnt_inc;
  logic [CNT_W-1:0] cycles;

  assign halt_hit = HALT_ALL ? (&halt_i) : (|halt_i);
  // Expiry is detected one cycle early so the exit-edge increment lands exactly on MAX_CYCLES.
  assign wdog_hit = WDOG_ON && (cycles == WDOG_LAST);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (start_i) begin
          state_d = ST_RESET;
          hold_d  = '0;
          cnt_clr = 1'b1;
        end
      end
      ST_RESET: begin
        if (hold_q == RST_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + RST_W'(1);
        end
      end
      ST_RUN: begin
        cnt_inc = 1'b1;
        if (halt_hit) begin
          state_d = ST_DONE;
        end else if (wdog_hit) begin
          state_d = ST_TIMEOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  run_ctrl_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .cnt_o (cycles)
  );

  // Status is decoded from the state register only, so start/halt never reach an output.
  always_comb begin
    core_rst_o = 1'b0;
    core_en_o  = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    timeout_o  = 1'b0;
    case (state_q)
      ST_IDLE:    core_rst_o = 1'b1;
      ST_RESET: begin
        core_rst_o = 1'b1;
        busy_o     = 1'b1;
      end
      ST_RUN: begin
        core_en_o = 1'b1;
        busy_o    = 1'b1;
      end
      ST_DONE:    done_o    = 1'b1;
      ST_TIMEOUT: timeout_o = WDOG_ON;
      default:    core_rst_o = 1'b1;
    endcase
  end

  assign cycles_o = cycles;

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - directed self-checking bench for run_ctrl
module tb_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_start;
  logic [0:0]  a_halt;
  logic        a_core_rst, a_core_en, a_busy, a_done, a_timeout;
  logic [15:0] a_cycles;

  logic        b_start;
  logic [3:0]  b_halt;
  logic        b_core_rst, b_core_en, b_busy, b_done, b_timeout;
  logic [15:0] b_cycles;

  logic        c_start;
  logic [0:0]  c_halt;
  logic        c_core_rst, c_core_en, c_busy, c_done, c_timeout;
  logic [3:0]  c_cycles;

  int checks = 0;
  int errors = 0;
  int n;
  int en_cnt;

  run_ctrl u_a (
    .clk_i(clk), .rst_i(rst), .start_i(a_start), .halt_i(a_halt),
    .core_rst_o(a_core_rst), .core_en_o(a_core_en), .busy_o(a_busy),
    .done_o(a_done), .timeout_o(a_timeout), .cycles_o(a_cycles)
  );

  run_ctrl #(.HALT_W(4), .HALT_ALL(1'b1)) u_b (
    .clk_i(clk), .rst_i(rst), .start_i(b_start), .halt_i(b_halt),
    .core_rst_o(b_core_rst), .core_en_o(b_core_en), .busy_o(b_busy),
    .done_o(b_done), .timeout_o(b_timeout), .cycles_o(b_cycles)
  );

  run_ctrl #(.CNT_W(4), .MAX_CYCLES(15)) u_c (
    .clk_i(clk), .rst_i(rst), .start_i(c_start), .halt_i(c_halt),
    .core_rst_o(c_core_rst), .core_en_o(c_core_en), .busy_o(c_busy),
    .done_o(c_done), .timeout_o(c_timeout), .cycles_o(c_cycles)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_halt = '0;
    b_start = 1'b0; b_halt = '0;
    c_start = 1'b0; c_halt = '0;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("idle_core_rst", a_core_rst, 1);
    check("idle_core_en", a_core_en, 0);
    check("idle_busy", a_busy, 0);
    check("idle_done", a_done, 0);
    check("idle_timeout", a_timeout, 0);
    check("idle_cycles", a_cycles, 0);
    check("idle_b_busy", b_busy, 0);
    check("idle_c_cycles", c_cycles, 0);

    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    n = 0;
    while (a_core_rst && n < 20) begin
      n++;
      tick();
    end
    check("rst_hold_len", n, 2);
    check("run_entry_en", a_core_en, 1);
    check("run_entry_cycles", a_cycles, 0);
    en_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      a_halt = (k == 10) ? 1'b1 : 1'b0;
      if (a_core_en) en_cnt++;
      tick();
    end
    a_halt = '0;
    check("run_en_len", en_cnt, 10);
    check("halt_done", a_done, 1);
    check("halt_cycles", a_cycles, 10);
    check("halt_core_en", a_core_en, 0);
    check("halt_core_rst", a_core_rst, 0);
    check("halt_busy", a_busy, 0);
    check("halt_timeout", a_timeout, 0);
    repeat (3) tick();
    check("done_hold_cycles", a_cycles, 10);
    check("done_hold_flag", a_done, 1);

    a_start = 1'b1;
    tick();
    check("restart_done_clr", a_done, 0);
    check("restart_busy", a_busy, 1);
    check("restart_core_rst", a_core_rst, 1);
    check("restart_cycles", a_cycles, 0);
    tick();
    tick();
    tick();
    a_start = 1'b0;
    check("busy_start_en", a_core_en, 1);
    check("busy_start_cycles", a_cycles, 1);
    repeat (3) tick();
    check("run5_cycles", a_cycles, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun_rst_busy", a_busy, 0);
    check("midrun_rst_core_rst", a_core_rst, 1);
    check("midrun_rst_core_en", a_core_en, 0);
    check("midrun_rst_cycles", a_cycles, 0);

    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    tick();
`ifdef RUN_CTRL_WDOG_EN
    repeat (34) tick();
    check("wdog_pre_busy", a_busy, 1);
    check("wdog_pre_cycles", a_cycles, 34);
    check("wdog_pre_timeout", a_timeout, 0);
    tick();
    check("wdog_timeout", a_timeout, 1);
    check("wdog_cycles", a_cycles, 35);
    check("wdog_busy", a_busy, 0);
    check("wdog_done", a_done, 0);
    repeat (2) tick();
    check("wdog_hold_cycles", a_cycles, 35);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("wdog_restart_clr", a_timeout, 0);
    check("wdog_restart_cycles", a_cycles, 0);
    tick();
    tick();
`else
    repeat (100) tick();
    check("nowdog_busy", a_busy, 1);
    check("nowdog_core_en", a_core_en, 1);
    check("nowdog_timeout", a_timeout, 0);
    check("nowdog_cycles", a_cycles, 100);
    a_halt = 1'b1;
    tick();
    a_halt = '0;
    check("nowdog_halt_done", a_done, 1);
    check("nowdog_halt_cycles", a_cycles, 101);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    tick();
`endif
    repeat (34) tick();
    a_halt = 1'b1;
    tick();
    a_halt = '0;
    check("prio_done", a_done, 1);
    check("prio_timeout", a_timeout, 0);
    check("prio_cycles", a_cycles, 35);

    rst = 1'b1;
    a_start = 1'b1;
    tick();
    rst = 1'b0;
    a_start = 1'b0;
    check("rst_prio_busy", a_busy, 0);
    check("rst_prio_core_rst", a_core_rst, 1);
    check("rst_prio_done", a_done, 0);
    check("rst_prio_cycles", a_cycles, 0);

    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    tick();
    tick();
    b_halt = 4'b0111;
    repeat (3) tick();
    check("all_partial_busy", b_busy, 1);
    check("all_partial_done", b_done, 0);
    check("all_partial_cycles", b_cycles, 3);
    b_halt = 4'b1111;
    tick();
    b_halt = '0;
    check("all_full_done", b_done, 1);
    check("all_full_cycles", b_cycles, 4);

    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    tick();
    tick();
    repeat (14) tick();
    check("sat_pre_cycles", c_cycles, 14);
    tick();
    check("sat_edge_cycles", c_cycles, 15);
    repeat (5) tick();
    check("sat_hold_cycles", c_cycles, 15);
`ifdef RUN_CTRL_WDOG_EN
    check("sat_wdog_timeout", c_timeout, 1);
`else
    check("sat_busy", c_busy, 1);
`endif
    c_halt = 1'b1;
    tick();
    c_halt = '0;
    check("sat_final_cycles", c_cycles, 15);
`ifndef RUN_CTRL_WDOG_EN
    check("sat_done", c_done, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 The block SHALL take parameter RST_CYCLES, default 2, the number of cycles core_rst is held high after a start.
REQ-002 The block SHALL take parameter MAX_CYCLES, default 35, the watchdog limit in RUN cycles (legal range 1..2^CNT_W-1).
REQ-003 The block SHALL take parameter CNT_W, default 16, the width of the cycle counter.
REQ-004 The block SHALL take parameter HALT_W, default 1, the number of halt channels.
REQ-005 The block SHALL take parameter HALT_ALL, default 0, where 0 means any channel halts and 1 means all channels must halt.
REQ-006 clk  in  1  single clock; all logic SHALL use its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  run request, sampled only in IDLE, DONE or TIMEOUT.
REQ-009 halt  in  HALT_W  halt indication per core/channel, sampled only in RUN.
REQ-010 core_rst  out  1  reset to the controlled core.
REQ-011 core_en  out  1  clock-enable/run to the controlled core.
REQ-012 busy  out  1  high in RESET or RUN.
REQ-013 done  out  1  high in DONE.
REQ-014 timeout  out  1  high in TIMEOUT.
REQ-015 cycles  out  CNT_W  number of RUN cycles elapsed in the current or last run.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, RESET, RUN, DONE and TIMEOUT.
REQ-017 IDLE SHALL drive core_rst=1, core_en=0, and start=1 SHALL move to RESET on the next edge.
REQ-018 The RESET entry edge SHALL clear cycles to 0 and the reset-hold counter to 0.
REQ-019 RESET SHALL drive core_rst=1 and core_en=0 for exactly RST_CYCLES cycles, then move to RUN; RST_CYCLES=0 SHALL be treated as 1.
REQ-020 RUN SHALL drive core_rst=0 and core_en=1, and SHALL increment cycles on every edge taken in RUN, including the exit edge.
REQ-021 In RUN, the halt condition SHALL be |halt when HALT_ALL=0 and &halt when HALT_ALL=1; if true, the next state SHALL be DONE.
REQ-022 In RUN, when cycles==MAX_CYCLES-1 and the halt condition is false, the next state SHALL be TIMEOUT, so cycles reads MAX_CYCLES.
REQ-023 When halt and watchdog expiry occur on the same edge, DONE SHALL take priority over TIMEOUT.
REQ-024 DONE and TIMEOUT SHALL drive core_rst=0 and core_en=0, and SHALL hold cycles and status until start=1, which moves to RESET and clears done/timeout.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 cycles SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 All outputs SHALL be registered or decoded from the state register only, with no combinational path from start or halt.

Reset
REQ-028 rst=1 SHALL force IDLE from any state, including mid-RESET or mid-RUN, on the next edge.
REQ-029 After reset, outputs SHALL read core_rst=1, core_en=0, busy=0, done=0, timeout=0 and cycles=0.
REQ-030 rst SHALL take priority over start on the same edge.

Configuration
REQ-031 With RUN_CTRL_WDOG_EN defined, the watchdog behaviour of REQ-022 and REQ-023 SHALL be compiled in.
REQ-032 Without RUN_CTRL_WDOG_EN, TIMEOUT SHALL be unreachable, MAX_CYCLES SHALL be ignored, timeout SHALL be tied to 0, and RUN SHALL exit only on halt or rst.

Structure
REQ-033 The state enum typedef and the default parameter constants SHALL live in the shared package run_ctrl_pkg.
REQ-034 The saturating, clearable cycle counter SHALL be a sub-module named run_ctrl_cnt, instantiated once.

Verification
REQ-035 Reset then idle: rst high for 1 cycle, then low with start=0 for 5 cycles -> core_rst=1, core_en=0, all flags 0, cycles=0.
REQ-036 Normal halt: RST_CYCLES=2, start pulsed once, halt=1 in the 10th RUN cycle -> core_rst high for exactly 2 cycles, then core_en high for 10 cycles, done=1 and cycles=10.
REQ-037 Watchdog: MAX_CYCLES=35, halt held at 0 -> timeout=1 after 35 RUN cycles with cycles=35; with RUN_CTRL_WDOG_EN undefined -> still in RUN at cycle 100 and timeout=0.
REQ-038 Priority and mode: halt=1 on the 35th RUN cycle -> done=1 and timeout=0; with HALT_W=4 and HALT_ALL=1, halt=4'b0111 -> stays in RUN, halt=4'b1111 -> done=1.
REQ-039 Mid-run reset and restart: rst pulsed in the 5th RUN cycle -> IDLE with cycles=0; start in DONE -> RESET with done cleared and cycles=0; start while busy -> no effect.
REQ-040 Saturation: CNT_W=4, MAX_CYCLES=15, watchdog undefined, halt asserted after 20 RUN cycles -> cycles reads 15 and does not wrap.
